// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn: registered 1-to-N stream demultiplexer.
// Each accepted input word is steered into a one-entry output register of the
// chosen channel. The channel is either addressed explicitly (in_sel) or taken
// from an internal round-robin pointer (rotate mode). Every channel drains
// independently through its own valid/ready handshake.
module demux_stream_1xn #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [SEL_W-1:0]              in_sel,
  output logic [(1<<SEL_W)-1:0]         out_valid,
  input  logic [(1<<SEL_W)-1:0]         out_ready,
  output logic [(1<<SEL_W)*DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]              rr_ptr,
  output logic [15:0]                   xfer_cnt
);

  localparam int N_OUT = 1 << SEL_W;

  // Per-channel output registers.
  logic [N_OUT-1:0]  valid_q;
  logic [N_OUT-1:0]  valid_d;
  logic [DATA_W-1:0] data_q [N_OUT];
  logic [DATA_W-1:0] data_d [N_OUT];

  // Shared input-side state.
  logic [SEL_W-1:0]  rr_ptr_q;
  logic [SEL_W-1:0]  rr_ptr_d;
  logic [15:0]       xfer_cnt_q;
  logic [15:0]       xfer_cnt_d;

  // Input-side decode.
  logic [SEL_W-1:0]  target;
  logic              accept;

  // Pick the target channel and decide whether the producer may hand over a
  // word; a full target that is draining this cycle still has room, which is
  // what gives one word per cycle into a single channel.
  always_comb begin
    target   = mode ? rr_ptr_q : in_sel;
    in_ready = !valid_q[target] || out_ready[target];
    accept   = in_valid && in_ready;
  end

  // Round-robin pointer and transfer counter next state. The pointer only
  // moves on accepted words in rotate mode, so a stalled target is never
  // skipped. Both wrap naturally at their register widths.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    xfer_cnt_d = xfer_cnt_q;
    if (accept) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
      if (mode) begin
        rr_ptr_d = rr_ptr_q + SEL_W'(1);
      end
    end
  end

  // Input-side state register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      xfer_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // One output slot per channel.
  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_chan
      logic load;
      logic drain;

      // Load wins over drain: a same-cycle drain and load keeps the slot full
      // with the new word. A drain alone empties the slot but leaves the last
      // word on the data lines.
      always_comb begin
        load        = accept && (target == SEL_W'(gi));
        drain       = valid_q[gi] && out_ready[gi];
        valid_d[gi] = valid_q[gi];
        data_d[gi]  = data_q[gi];
        if (load) begin
          valid_d[gi] = 1'b1;
          data_d[gi]  = in_data;
        end else if (drain) begin
          valid_d[gi] = 1'b0;
        end
      end

      // Channel slot register; reset discards any buffered word.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
          data_q[gi]  <= '0;
        end else begin
          valid_q[gi] <= valid_d[gi];
          data_q[gi]  <= data_d[gi];
        end
      end

      assign out_valid[gi]                    = valid_q[gi];
      assign out_data[gi*DATA_W +: DATA_W]    = data_q[gi];
    end
  endgenerate

  assign rr_ptr   = rr_ptr_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Testbench for demux_stream_1xn (DATA_W=8, SEL_W=3).
// Stimulus pushes expected words into per-channel queues; a monitor pops them
// whenever a channel handshakes and compares against the DUT.
module tb_demux_stream_1xn;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [2:0]  in_sel = '0;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = '0;
  logic [63:0] out_data;
  logic [2:0]  rr_ptr;
  logic [15:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: channel occupancy, expected words, pointer, counter.
  logic [7:0] exp_q [N][$];
  logic [7:0] m_full = '0;
  int         m_rr = 0;
  int         m_cnt = 0;

  demux_stream_1xn #(.DATA_W(8), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rr_ptr(rr_ptr), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) exp_q[k].delete();
    m_full = '0;
    m_rr   = 0;
    m_cnt  = 0;
  endtask

  // Model update at each active edge: inputs are stable here (driven at +1).
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        int  t;
        bit  acc;
        t   = mode ? m_rr : int'(in_sel);
        acc = in_valid && (!m_full[t] || out_ready[t]);
        for (int k = 0; k < N; k++)
          if (m_full[k] && out_ready[k]) m_full[k] = 1'b0;
        if (acc) begin
          m_full[t] = 1'b1;
          exp_q[t].push_back(in_data);
          m_cnt = (m_cnt + 1) % 65536;
          if (mode) m_rr = (m_rr + 1) % N;
        end
      end
    end
  end

  // Monitor on the falling edge: status compare and per-channel pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        int t;
        t = mode ? m_rr : int'(in_sel);
        chk("out_valid", 64'(out_valid), 64'(m_full));
        chk("rr_ptr", 64'(rr_ptr), 64'(m_rr));
        chk("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
        chk("in_ready", 64'(in_ready), 64'(!m_full[t] || out_ready[t]));
        for (int k = 0; k < N; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            if (exp_q[k].size() == 0) begin
              chk($sformatf("unexpected_word_ch%0d", k), 64'(out_data[k*8 +: 8]), 64'hx);
            end else begin
              logic [7:0] e;
              e = exp_q[k].pop_front();
              chk($sformatf("data_ch%0d", k), 64'(out_data[k*8 +: 8]), 64'(e));
              $display("ch%0d delivered %02h (expected %02h)", k, out_data[k*8 +: 8], e);
            end
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted; returns at edge+1.
  task automatic send(input logic [7:0] d, input int sel);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = 3'(sel);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) begin
      chk("send_timeout", 64'd0, 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Asynchronous reset pulse between clock edges, checked before any edge.
  task automatic reset_pulse();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_rr_ptr", 64'(rr_ptr), 64'd0);
    chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    #1;
    rst = 1'b0;
    sync();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    #3;
    chk("por_out_valid", 64'(out_valid), 64'd0);
    chk("por_out_data", out_data, 64'd0);
    chk("por_rr_ptr", 64'(rr_ptr), 64'd0);
    chk("por_xfer_cnt", 64'(xfer_cnt), 64'd0);
    chk("por_in_ready", 64'(in_ready), 64'd1);
    #19;
    rst = 1'b0;
    sync();

    // Fill all channels in addressed mode with consumers stalled.
    mode = 1'b0;
    out_ready = '0;
    for (int k = 0; k < N; k++) send(8'hA0 + 8'(k), k);
    @(negedge clk);
    chk("fill_out_valid", 64'(out_valid), 64'hFF);
    chk("fill_xfer_cnt", 64'(xfer_cnt), 64'd8);
    for (int k = 0; k < N; k++)
      chk($sformatf("fill_data%0d", k), 64'(out_data[k*8 +: 8]), 64'(8'hA0 + 8'(k)));
    sync();
    in_valid = 1'b1; in_sel = 3'd3; in_data = 8'h99;
    repeat (3) begin
      @(negedge clk);
      chk("ninth_in_ready", 64'(in_ready), 64'd0);
    end
    sync();
    in_valid = 1'b0;

    // Back-to-back stream into channel 2.
    out_ready = 8'h04;
    for (int i = 1; i <= 16; i++) send(8'(i), 2);
    repeat (2) sync();
    out_ready = 8'hFF;
    repeat (3) sync();

    // Rotate mode, ten words with wrap.
    mode = 1'b1;
    for (int i = 0; i < 10; i++) send(8'hD0 + 8'(i), 0);
    @(negedge clk);
    chk("rotate_rr_ptr", 64'(rr_ptr), 64'd2);
    sync();
    mode = 1'b0;
    for (int i = 0; i < 4; i++) send(8'($urandom), int'($urandom_range(0, 7)));
    @(negedge clk);
    chk("addressed_rr_hold", 64'(rr_ptr), 64'd2);
    sync();

    // Stall in rotate mode on a full channel 1.
    out_ready = 8'hFD;
    send(8'h11, 1);
    mode = 1'b1;
    for (int i = 0; i < 7; i++) send(8'h20 + 8'(i), 0);
    in_valid = 1'b1; in_data = 8'h77;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_rr_ptr", 64'(rr_ptr), 64'd1);
    end
    sync();
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("unstall_in_ready", 64'(in_ready), 64'd1);
    sync();
    out_ready[1] = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("unstall_rr_ptr", 64'(rr_ptr), 64'd2);
    chk("unstall_valid1", 64'(out_valid[1]), 64'd1);
    sync();

    // Reset mid-stream: three channels full, xfer_cnt = 5.
    reset_pulse();
    mode = 1'b0;
    out_ready = 8'h20;
    send(8'h51, 5);
    send(8'h52, 5);
    send(8'h60, 0);
    send(8'h61, 1);
    send(8'h62, 2);
    @(negedge clk);
    chk("pre_rst_xfer_cnt", 64'(xfer_cnt), 64'd5);
    chk("pre_rst_valid", 64'(out_valid), 64'h07);
    reset_pulse();
    out_ready = '0;
    send(8'h5A, 4);
    @(negedge clk);
    chk("post_rst_xfer_cnt", 64'(xfer_cnt), 64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'h10);
    chk("post_rst_data4", 64'(out_data[32 +: 8]), 64'h5A);
    sync();

    // Randomized traffic.
    repeat (2000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      in_sel    = 3'($urandom);
      mode      = ($urandom_range(0, 3) == 0);
      out_ready = 8'($urandom);
      sync();
    end
    in_valid = 1'b0;
    out_ready = 8'hFF;
    repeat (3) sync();

    // Counter wrap: 65537 accepts from reset.
    reset_pulse();
    out_ready = 8'hFF;
    in_valid = 1'b1;
    repeat (65537) begin
      in_data = 8'($urandom);
      in_sel  = 3'($urandom);
      mode    = 1'($urandom_range(0, 1));
      sync();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_xfer_cnt", 64'(xfer_cnt), 64'd1);
    repeat (3) sync();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
